apb_fsm_controller: RTL and testbench
=====================================

# apb_fsm_controller

APB master-side sequencer for the AHB-to-APB bridge. It takes the registered transfer qualifier, address and write flag produced by the bridge's AHB slave interface, runs the APB SETUP/ACCESS protocol toward three peripheral regions, and stalls the AHB master through `Hreadyout` until each APB transfer completes. A programmable PREADY timeout prevents a hung peripheral from locking the AHB bus.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles waiting for `Pready`; 0 disables the timeout.
- `CNT_W`, 8, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- `Hclk` in 1: single clock.
- `Hreset` in 1: synchronous, active-high reset.
- `valid` in 1: registered AHB transfer qualifier; marks the AHB data-phase cycle.
- `Haddr1` in ADDR_W: transfer address, aligned with `valid`.
- `Hwritereg` in 1: transfer direction, aligned with `valid` (1 = write).
- `Hwdata` in DATA_W: live AHB write data; valid in the `valid` cycle.
- `Pready` in 1: APB completer ready.
- `Pselx` out 3: one-hot APB select.
- `Penable` out 1: APB enable.
- `Pwrite` out 1: APB direction.
- `Paddr` out ADDR_W: APB address.
- `Pwdata` out DATA_W: APB write data.
- `Hreadyout` out 1: AHB ready. It is tied externally to the bridge's `Hreadyin`.
- `timeout_pulse` out 1: one-cycle flag set when a transfer is ended by the timeout.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- **IDLE**
  - `Pselx`=000 and `Penable`=0.
  - If `valid`=1: capture `Haddr1`→`Paddr`, `Hwritereg`→`Pwrite` and `Hwdata`→`Pwdata`, then go to SETUP.
- **SETUP**
  - `Pselx`=decode(`Paddr`) and `Penable`=0.
  - Always go to ACCESS next cycle. The timeout counter is cleared.
- **ACCESS**
  - `Pselx` is held and `Penable`=1.
  - If `Pready`=1: go to IDLE.
  - Else if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES−1: go to IDLE and assert `timeout_pulse` on the following cycle.
  - Otherwise increment the counter.
- **Select decode** uses `Paddr[27:26]`: 00→001, 01→010, 10→100, 11→000.
  - 11 cannot occur because `valid` only asserts for 0x8000_0000–0x8BFF_FFFF.
  - If 11 does occur, the transfer still runs with `Pselx`=000 and completes on `Pready` or timeout.
- **`Hreadyout`** is combinational:
  - 1 when (IDLE and `valid`=0), or (ACCESS and (`Pready`=1 or timeout expiry)), or `Hreset`=1.
  - 0 otherwise, including IDLE with `valid`=1, and all of SETUP.
- **Output registers:** `Paddr`, `Pwrite` and `Pwdata` are registered and hold their values after completion until the next capture. Read data goes straight from `Prdata` to `Hrdata` outside this block.
- **`valid` outside IDLE is ignored.** It cannot occur while `Hreadyin`=`Hreadyout`, because the master holds the next address phase while `Hreadyout` is low.
- **Reset values** (all outputs): `Pselx`=000, `Penable`=0, `Pwrite`=0, `Paddr`=0, `Pwdata`=0, `timeout_pulse`=0, `Hreadyout`=1. State is IDLE and the counter is 0.
- **Reset mid-transfer:** the FSM returns to IDLE on the next edge. The APB transfer is abandoned, with `Pselx`/`Penable` low the cycle after reset is sampled. `valid` is ignored while `Hreset`=1.

## Timing
- A transfer with no wait states takes 3 cycles from `valid`:
  - C0: IDLE, `valid`=1, `Hreadyout`=0.
  - C1: SETUP.
  - C2: ACCESS with `Pready`=1, `Hreadyout`=1. The AHB data phase ends at the end of C2.
- Each cycle of `Pready`=0 in ACCESS adds one cycle.
- **Back-to-back:** the next `valid` may arrive in C3, and C3 then behaves as a new C0. No idle cycle is needed in between.
- **Timeout:** with TIMEOUT_CYCLES=N, ACCESS lasts at most N cycles. `Hreadyout`=1 in the Nth ACCESS cycle, and `timeout_pulse`=1 in the following cycle.
- `Pready`=1 in the same cycle as expiry counts as a normal completion, with no pulse.
- `Paddr`, `Pwrite`, `Pwdata` and `Pselx` are stable from SETUP through the final ACCESS cycle.

## Test plan
- **Single write:** `valid`=1, `Haddr1`=0x8000_0010, `Hwritereg`=1, `Hwdata`=0xDEAD_BEEF, `Pready`=1.
  - Expect SETUP next cycle with `Pselx`=001, `Pwrite`=1, `Pwdata`=0xDEAD_BEEF, `Penable`=0.
  - Expect ACCESS with `Penable`=1 and `Hreadyout`=1 two cycles after `valid`.
- **Read with wait states:** `Haddr1`=0x8400_0004, `Hwritereg`=0, `Pready` low for 3 ACCESS cycles.
  - Expect `Pselx`=010 and `Hreadyout`=0 for 5 cycles, then 1 in the 6th cycle after `valid`.
- **Back-to-back:** write to 0x8800_0000, then `valid` for a read to 0x8000_0008 in the cycle after completion.
  - Expect `Pselx` 100 then 001, no idle gap, and `Penable` low in each SETUP.
- **Timeout:** TIMEOUT_CYCLES=4, `Pready` held 0.
  - Expect exactly 4 ACCESS cycles, `Hreadyout`=1 in the 4th, `timeout_pulse`=1 for one cycle, then IDLE.
  - With `Pready`=1 in the 4th cycle, expect no pulse.
- **Reset mid-ACCESS:** assert `Hreset` for 1 cycle during a wait-stated ACCESS.
  - Expect `Hreadyout`=1 immediately, and `Pselx`=000, `Penable`=0, `Paddr`=0 after the edge.
  - A subsequent `valid` starts a clean transfer.
- **Decode edge:** `Haddr1`=0x83FF_FFFC gives `Pselx`=001; 0x8400_0000 gives 010; 0x8BFF_FFFC gives 100.

Source files
------------

// File: rtl/apb_fsm_controller.sv
// APB master-side sequencer for the AHB-to-APB bridge: IDLE/SETUP/ACCESS control
// toward three peripheral regions, AHB stall via Hreadyout, and a PREADY timeout.
module apb_fsm_controller #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic              Hclk,
  input  logic              Hreset,
  input  logic              valid,
  input  logic [ADDR_W-1:0] Haddr1,
  input  logic              Hwritereg,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic              Pready,
  output logic [2:0]        Pselx,
  output logic              Penable,
  output logic              Pwrite,
  output logic [ADDR_W-1:0] Paddr,
  output logic [DATA_W-1:0] Pwdata,
  output logic              Hreadyout,
  output logic              timeout_pulse
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Count value seen in the last permitted ACCESS cycle; only meaningful when the timeout is enabled.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt;
  logic             expire;
  logic [2:0]       sel;

  function automatic logic [2:0] sel_decode(input logic [1:0] region);
    case (region)
      2'b00:   sel_decode = 3'b001;
      2'b01:   sel_decode = 3'b010;
      2'b10:   sel_decode = 3'b100;
      default: sel_decode = 3'b000;
    endcase
  endfunction

  assign sel = sel_decode(Paddr[27:26]);

  always_comb begin
    state_d   = state;
    Pselx     = 3'b000;
    Penable   = 1'b0;
    expire    = 1'b0;
    Hreadyout = 1'b0;
    case (state)
      IDLE: begin
        Hreadyout = !valid;
        if (valid) state_d = SETUP;
      end
      SETUP: begin
        Pselx   = sel;
        state_d = ACCESS;
      end
      ACCESS: begin
        Pselx   = sel;
        Penable = 1'b1;
        // A same-cycle Pready wins over expiry, so no pulse is raised then.
        expire  = !Pready && (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
        if (Pready || expire) begin
          state_d   = IDLE;
          Hreadyout = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Keep the AHB side moving while the bridge is held in reset.
    if (Hreset) Hreadyout = 1'b1;
  end

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state         <= IDLE;
      cnt           <= '0;
      Paddr         <= '0;
      Pwrite        <= 1'b0;
      Pwdata        <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      state         <= state_d;
      timeout_pulse <= expire;
      if (state == IDLE && valid) begin
        Paddr  <= Haddr1;
        Pwrite <= Hwritereg;
        Pwdata <= Hwdata;
      end
      if (state == SETUP)
        cnt <= '0;
      else if (state == ACCESS && !Pready && !expire)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_fsm_controller.sv
// Directed bench for apb_fsm_controller: cycle checks plus a transfer scoreboard
// that is filled at each valid and drained at each APB completion.
module tb_apb_fsm_controller;

  logic        Hclk = 1'b0;
  logic        Hreset;
  logic        valid;
  logic [31:0] Haddr1;
  logic        Hwritereg;
  logic [31:0] Hwdata;
  logic        Pready;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
  logic        timeout_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] data;
    logic [2:0]  sel;
  } xfer_t;

  xfer_t sb[$];

  apb_fsm_controller #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4), .CNT_W(8)
  ) dut (
    .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Haddr1(Haddr1),
    .Hwritereg(Hwritereg), .Hwdata(Hwdata), .Pready(Pready),
    .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr),
    .Pwdata(Pwdata), .Hreadyout(Hreadyout), .timeout_pulse(timeout_pulse)
  );

  always #5 Hclk = ~Hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] exp_sel(input logic [31:0] a);
    case (a[27:26])
      2'b00:   exp_sel = 3'b001;
      2'b01:   exp_sel = 3'b010;
      2'b10:   exp_sel = 3'b100;
      default: exp_sel = 3'b000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] a, input logic w, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.wr = w; x.data = d; x.sel = exp_sel(a);
    sb.push_back(x);
  endtask

  // Called mid-cycle: a completing ACCESS retires the oldest expected transfer.
  task automatic sb_check();
    xfer_t x;
    if (Penable === 1'b1 && Hreadyout === 1'b1 && Hreset === 1'b0) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        x = sb.pop_front();
        chk("sb_paddr", Paddr, x.addr);
        chk("sb_pwrite", 32'(Pwrite), 32'(x.wr));
        chk("sb_pwdata", Pwdata, x.data);
        chk("sb_pselx", 32'(Pselx), 32'(x.sel));
      end
    end
  endtask

  // Drive one cycle's inputs just after the edge, then sample at the falling edge.
  task automatic drive(input logic v, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic pr, input logic rst);
    @(posedge Hclk); #1;
    valid = v; Haddr1 = a; Hwritereg = w; Hwdata = d; Pready = pr; Hreset = rst;
    @(negedge Hclk);
    sb_check();
  endtask

  task automatic idle_cycle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d, input logic pr);
    sb_push(a, w, d);
    drive(1'b1, a, w, d, pr, 1'b0);
    chk("c0_hreadyout", 32'(Hreadyout), 32'h0);
    chk("c0_pselx", 32'(Pselx), 32'h0);
  endtask

  initial begin
    Hreset = 1'b1; valid = 1'b0; Haddr1 = '0; Hwritereg = 1'b0; Hwdata = '0; Pready = 1'b0;

    // Reset
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b1, 32'h8000_0040, 1'b1, 32'h1111_1111, 1'b0, 1'b1);
    chk("rst_hreadyout", 32'(Hreadyout), 32'h1);
    idle_cycle();
    chk("rst_pselx", 32'(Pselx), 32'h0);
    chk("rst_penable", 32'(Penable), 32'h0);
    chk("rst_pwrite", 32'(Pwrite), 32'h0);
    chk("rst_paddr", Paddr, 32'h0);
    chk("rst_pwdata", Pwdata, 32'h0);
    chk("rst_tpulse", 32'(timeout_pulse), 32'h0);
    chk("rst_hreadyout_idle", 32'(Hreadyout), 32'h1);

    // Single write, no wait states
    start(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wr_setup_pselx", 32'(Pselx), 32'h1);
    chk("wr_setup_penable", 32'(Penable), 32'h0);
    chk("wr_setup_pwrite", 32'(Pwrite), 32'h1);
    chk("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
    chk("wr_setup_hreadyout", 32'(Hreadyout), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("wr_access_penable", 32'(Penable), 32'h1);
    chk("wr_access_hreadyout", 32'(Hreadyout), 32'h1);
    idle_cycle();
    chk("wr_idle_pselx", 32'(Pselx), 32'h0);
    chk("wr_idle_penable", 32'(Penable), 32'h0);
    chk("wr_hold_paddr", Paddr, 32'h8000_0010);

    // Read with three wait states; a stray valid during ACCESS is ignored
    start(32'h8400_0004, 1'b0, 32'h1234_5678, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rd_setup_pselx", 32'(Pselx), 32'h2);
    chk("rd_setup_hreadyout", 32'(Hreadyout), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h8800_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("rd_wait_hreadyout", 32'(Hreadyout), 32'h0);
      chk("rd_wait_penable", 32'(Penable), 32'h1);
      chk("rd_wait_pselx", 32'(Pselx), 32'h2);
      chk("rd_wait_paddr", Paddr, 32'h8400_0004);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("rd_done_hreadyout", 32'(Hreadyout), 32'h1);
    chk("rd_done_pwrite", 32'(Pwrite), 32'h0);

    // Back-to-back: write then read with no idle gap
    start(32'h8800_0000, 1'b1, 32'hA5A5_0001, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("b2b_setup1_pselx", 32'(Pselx), 32'h4);
    chk("b2b_setup1_penable", 32'(Penable), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("b2b_access1_hreadyout", 32'(Hreadyout), 32'h1);
    start(32'h8000_0008, 1'b0, 32'h0000_0002, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("b2b_setup2_pselx", 32'(Pselx), 32'h1);
    chk("b2b_setup2_penable", 32'(Penable), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("b2b_access2_hreadyout", 32'(Hreadyout), 32'h1);

    // Timeout: Pready held low for the whole ACCESS window
    start(32'h8000_0020, 1'b1, 32'h0BAD_F00D, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      chk("to_penable", 32'(Penable), 32'h1);
      chk("to_hreadyout", 32'(Hreadyout), (i == 4) ? 32'h1 : 32'h0);
      chk("to_pulse_during", 32'(timeout_pulse), 32'h0);
    end
    idle_cycle();
    chk("to_pulse", 32'(timeout_pulse), 32'h1);
    chk("to_idle_penable", 32'(Penable), 32'h0);
    chk("to_idle_pselx", 32'(Pselx), 32'h0);
    idle_cycle();
    chk("to_pulse_one_cycle", 32'(timeout_pulse), 32'h0);

    // Pready in the expiry cycle completes normally
    start(32'h8400_0030, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 32'h0, 1'b0, 32'h0, (i == 4), 1'b0);
      chk("tor_hreadyout", 32'(Hreadyout), (i == 4) ? 32'h1 : 32'h0);
    end
    idle_cycle();
    chk("tor_no_pulse", 32'(timeout_pulse), 32'h0);

    // Reset in the middle of a wait-stated ACCESS abandons the transfer
    start(32'h8400_0100, 1'b1, 32'hCAFE_0001, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("mr_wait_hreadyout", 32'(Hreadyout), 32'h0);
    sb.delete();
    drive(1'b1, 32'h8800_0004, 1'b1, 32'h7777_7777, 1'b0, 1'b1);
    chk("mr_hreadyout", 32'(Hreadyout), 32'h1);
    idle_cycle();
    chk("mr_pselx", 32'(Pselx), 32'h0);
    chk("mr_penable", 32'(Penable), 32'h0);
    chk("mr_paddr", Paddr, 32'h0);
    chk("mr_pwdata", Pwdata, 32'h0);
    start(32'h8BFF_FFFC, 1'b1, 32'h5555_AAAA, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("mr_clean_setup_pselx", 32'(Pselx), 32'h4);
    chk("mr_clean_paddr", Paddr, 32'h8BFF_FFFC);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("mr_clean_done", 32'(Hreadyout), 32'h1);

    // Decode edges, plus the unmapped region completing with no select
    start(32'h83FF_FFFC, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("dec_83fffffc", 32'(Pselx), 32'h1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    start(32'h8400_0000, 1'b0, 32'h0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("dec_84000000", 32'(Pselx), 32'h2);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    start(32'h8C00_0000, 1'b1, 32'h0000_00C0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("dec_unmapped", 32'(Pselx), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk("dec_unmapped_done", 32'(Hreadyout), 32'h1);
    idle_cycle();

    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
